// File: rtl/sa_tile_stream_driver.sv
// ============================================================================
// Module   : sa_tile_stream_driver
// Purpose  : Streams one K-slice per cycle from flat W/X tile buffers into an
//            output-stationary systolic array over a valid/ready handshake,
//            then drains and captures the result tile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_tile_stream_driver #(
    parameter int M        = 8,
    parameter int N        = 8,
    parameter int KMAX     = 1024,
    parameter int DW       = 32,
    parameter int DRAIN_TO = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tile_start,
    input  logic [15:0]            K_len,
    input  logic                   acc_mode,
    input  logic                   abort,
    output logic                   tile_busy,
    output logic                   tile_done,
    output logic [1:0]             tile_err,
    input  logic [M*KMAX*DW-1:0]   W_tile_flat,
    input  logic [KMAX*N*DW-1:0]   X_tile_flat,
    output logic                   step_valid,
    output logic [M*DW-1:0]        a_row_flat,
    output logic [N*DW-1:0]        b_col_flat,
    output logic                   k_first,
    output logic                   k_last,
    input  logic                   step_ready,
    input  logic [M*N*DW-1:0]      c_out_flat,
    input  logic [M*N-1:0]         c_valid_flat,
    output logic [M*N*DW-1:0]      res_flat,
    output logic                   res_valid
);

    localparam int          KW       = $clog2(KMAX + 1);
    localparam int          WAW      = $clog2(M * KMAX * DW);
    localparam int          XAW      = $clog2(KMAX * N * DW);
    localparam int          DCW      = $clog2(DRAIN_TO + 1);
    localparam logic [15:0] C_KMAX16 = 16'(KMAX);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [KW-1:0]        kk_q;
    logic [KW-1:0]        klen_q;
    logic                 acc_q;
    logic [DCW-1:0]       drain_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [1:0]           err_q;
    logic                 sv_q;
    logic [M*DW-1:0]      a_q;
    logic [N*DW-1:0]      b_q;
    logic                 kf_q;
    logic                 kl_q;
    logic [M*N*DW-1:0]    res_q;
    logic                 resv_q;

    // Index of the beat to load next: the current kk before the first beat,
    // kk+1 once a beat is on the bus (only used when that beat transfers).
    logic [KW-1:0]        kk_d;
    logic [M*DW-1:0]      a_d;
    logic [N*DW-1:0]      b_d;
    logic                 kf_d;
    logic                 kl_d;

    assign kk_d = sv_q ? (kk_q + KW'(1)) : kk_q;
    assign kf_d = (kk_d == '0) & ~acc_q;
    assign kl_d = (kk_d == (klen_q - KW'(1)));

    // a[i] = W(i,kk): row i of W occupies a contiguous KMAX*DW window.
    for (genvar i = 0; i < M; i++) begin : g_a_row
        localparam logic [WAW-1:0] C_BASE = WAW'(i * KMAX * DW);
        assign a_d[i*DW +: DW] = W_tile_flat[C_BASE + WAW'(kk_d) * WAW'(DW) +: DW];
    end

    // b[j] = X(kk,j): row kk of X occupies a contiguous N*DW window.
    for (genvar j = 0; j < N; j++) begin : g_b_col
        localparam logic [XAW-1:0] C_OFS = XAW'(j * DW);
        assign b_d[j*DW +: DW] = X_tile_flat[XAW'(kk_d) * XAW'(N * DW) + C_OFS +: DW];
    end

    // Tile sequencer: start/range check, beat issue, drain capture, completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kk_q        <= '0;
            klen_q      <= '0;
            acc_q       <= 1'b0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            sv_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            kf_q        <= 1'b0;
            kl_q        <= 1'b0;
            res_q       <= '0;
            resv_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (busy_q) begin
                        // Cycle after the done pulse: release busy, no start yet.
                        busy_q <= 1'b0;
                    end else if (tile_start) begin
                        busy_q <= 1'b1;
                        resv_q <= 1'b0;
                        klen_q <= KW'(K_len);
                        acc_q  <= acc_mode;
                        kk_q   <= '0;
                        if (K_len == 16'd0) begin
                            err_q   <= ERR_OK;
                            state_q <= S_DONE;
                        end else if (K_len > C_KMAX16) begin
                            err_q   <= ERR_RANGE;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= ERR_OK;
                            state_q <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (abort) begin
                        sv_q    <= 1'b0;
                        kf_q    <= 1'b0;
                        kl_q    <= 1'b0;
                        err_q   <= ERR_ABORT;
                        state_q <= S_DONE;
                    end else if (!sv_q) begin
                        sv_q <= 1'b1;
                        a_q  <= a_d;
                        b_q  <= b_d;
                        kf_q <= kf_d;
                        kl_q <= kl_d;
                    end else if (step_ready) begin
                        if (kl_q) begin
                            sv_q        <= 1'b0;
                            kf_q        <= 1'b0;
                            kl_q        <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= S_DRAIN;
                        end else begin
                            kk_q <= kk_d;
                            a_q  <= a_d;
                            b_q  <= b_d;
                            kf_q <= kf_d;
                            kl_q <= kl_d;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        err_q   <= ERR_ABORT;
                        state_q <= S_DONE;
                    end else if (&c_valid_flat) begin
                        res_q   <= c_out_flat;
                        resv_q  <= 1'b1;
                        err_q   <= ERR_OK;
                        state_q <= S_DONE;
                    end else if (drain_cnt_q == DCW'(DRAIN_TO - 1)) begin
                        err_q   <= ERR_TIMEOUT;
                        state_q <= S_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DCW'(1);
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tile_busy  = busy_q;
    assign tile_done  = done_q;
    assign tile_err   = err_q;
    assign step_valid = sv_q;
    assign a_row_flat = a_q;
    assign b_col_flat = b_q;
    assign k_first    = kf_q;
    assign k_last     = kl_q;
    assign res_flat   = res_q;
    assign res_valid  = resv_q;

endmodule

`default_nettype wire

// File: tb/tb_sa_tile_stream_driver.sv
// ============================================================================
// Module   : tb_sa_tile_stream_driver
// Purpose  : Directed self-checking bench for sa_tile_stream_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_tile_stream_driver;

    localparam int M        = 4;
    localparam int N        = 4;
    localparam int KMAX     = 16;
    localparam int DW       = 16;
    localparam int DRAIN_TO = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  tile_start = 1'b0;
    logic [15:0]           K_len = 16'd0;
    logic                  acc_mode = 1'b0;
    logic                  abort = 1'b0;
    logic                  step_ready = 1'b0;
    logic [M*KMAX*DW-1:0]  W_tile_flat;
    logic [KMAX*N*DW-1:0]  X_tile_flat;
    logic [M*N*DW-1:0]     c_out_flat;
    logic [M*N-1:0]        c_valid_flat = '0;
    logic [M*N*DW-1:0]     exp_res;

    logic                  tile_busy, tile_done, step_valid, k_first, k_last, res_valid;
    logic [1:0]            tile_err;
    logic [M*DW-1:0]       a_row_flat;
    logic [N*DW-1:0]       b_col_flat;
    logic [M*N*DW-1:0]     res_flat;

    int errors = 0;
    int checks = 0;

    sa_tile_stream_driver #(
        .M(M), .N(N), .KMAX(KMAX), .DW(DW), .DRAIN_TO(DRAIN_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .K_len(K_len),
        .acc_mode(acc_mode), .abort(abort), .tile_busy(tile_busy),
        .tile_done(tile_done), .tile_err(tile_err), .W_tile_flat(W_tile_flat),
        .X_tile_flat(X_tile_flat), .step_valid(step_valid), .a_row_flat(a_row_flat),
        .b_col_flat(b_col_flat), .k_first(k_first), .k_last(k_last),
        .step_ready(step_ready), .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat),
        .res_flat(res_flat), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [15:0] kl, input logic acc);
        K_len      = kl;
        acc_mode   = acc;
        tile_start = 1'b1;
        tick();
        tile_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        if (tile_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %0h want 0", tile_busy); end checks++;
        if (tile_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %0h want 0", tile_done); end checks++;
        if (tile_err !== 2'd0)   begin errors++; $display("FAIL rst_err: got %0h want 0", tile_err); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", step_valid); end checks++;
        if (a_row_flat !== '0)   begin errors++; $display("FAIL rst_a: got %0h want 0", a_row_flat); end checks++;
        if (b_col_flat !== '0)   begin errors++; $display("FAIL rst_b: got %0h want 0", b_col_flat); end checks++;
        if ({k_first, k_last} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %0h want 0", {k_first, k_last}); end checks++;
        if (res_valid !== 1'b0)  begin errors++; $display("FAIL rst_resv: got %0h want 0", res_valid); end checks++;
        if (res_flat !== '0)     begin errors++; $display("FAIL rst_res: got %0h want 0", res_flat); end checks++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        step_ready = 1'b1;
        start_tile(16'd4, 1'b0);
        if (tile_busy !== 1'b1)  begin errors++; $display("FAIL basic_busy: got %0h want 1", tile_busy); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL basic_nobeat_yet: got %0h want 0", step_valid); end checks++;
        tick();
        for (int b = 0; b < 4; b++) begin
            if (step_valid !== 1'b1) begin errors++; $display("FAIL basic_valid b%0d: got %0h want 1", b, step_valid); end checks++;
            if (k_first !== (b == 0)) begin errors++; $display("FAIL basic_kfirst b%0d: got %0h want %0h", b, k_first, (b == 0)); end checks++;
            if (k_last !== (b == 3))  begin errors++; $display("FAIL basic_klast b%0d: got %0h want %0h", b, k_last, (b == 3)); end checks++;
            if (a_row_flat[2*DW +: DW] !== 16'(32 + b)) begin errors++; $display("FAIL basic_a2 b%0d: got %0h want %0h", b, a_row_flat[2*DW +: DW], 32 + b); end checks++;
            if (b_col_flat[1*DW +: DW] !== 16'(b*16 + 1)) begin errors++; $display("FAIL basic_b1 b%0d: got %0h want %0h", b, b_col_flat[1*DW +: DW], b*16 + 1); end checks++;
            tick();
        end
        if (step_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %0h want 0", step_valid); end checks++;
        tick();
        tick();
        if (tile_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %0h want 0", tile_done); end checks++;
        c_valid_flat = '1;
        tick();
        c_valid_flat = '0;
        if (res_valid !== 1'b1)  begin errors++; $display("FAIL basic_resv: got %0h want 1", res_valid); end checks++;
        if (res_flat !== exp_res) begin errors++; $display("FAIL basic_res: got %0h want %0h", res_flat, exp_res); end checks++;
        tick();
        if (tile_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0h want 1", tile_done); end checks++;
        if (tile_err !== 2'd0)  begin errors++; $display("FAIL basic_err: got %0h want 0", tile_err); end checks++;
        if (tile_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %0h want 1", tile_busy); end checks++;
        tick();
        if (tile_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0h want 0", tile_done); end checks++;
        if (tile_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: got %0h want 0", tile_busy); end checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_resv_hold: got %0h want 1", res_valid); end checks++;
    endtask

    task automatic test_stall();
        logic pat [6];
        int   exp_k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        step_ready = 1'b0;
        start_tile(16'd3, 1'b0);
        tick();
        exp_k = 0;
        for (int c = 0; c < 6; c++) begin
            step_ready = pat[c];
            tile_start = (c == 1);
            K_len      = (c == 1) ? 16'd0 : 16'd3;
            if (step_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %0h want 1", c, step_valid); end checks++;
            if (a_row_flat[0 +: DW] !== 16'(exp_k)) begin errors++; $display("FAIL stall_a0 c%0d: got %0h want %0h", c, a_row_flat[0 +: DW], exp_k); end checks++;
            if (b_col_flat[0 +: DW] !== 16'(exp_k*16)) begin errors++; $display("FAIL stall_b0 c%0d: got %0h want %0h", c, b_col_flat[0 +: DW], exp_k*16); end checks++;
            if (k_last !== (exp_k == 2)) begin errors++; $display("FAIL stall_klast c%0d: got %0h want %0h", c, k_last, (exp_k == 2)); end checks++;
            tick();
            if (pat[c]) exp_k++;
        end
        tile_start = 1'b0;
        step_ready = 1'b1;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %0h want 0", step_valid); end checks++;
        c_valid_flat = '1;
        tick();
        c_valid_flat = '0;
        tick();
        if (tile_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0h want 1", tile_done); end checks++;
        tick();
    endtask

    task automatic test_acc();
        step_ready = 1'b1;
        start_tile(16'd2, 1'b1);
        tick();
        if ({k_first, k_last} !== 2'b00) begin errors++; $display("FAIL acc_b0_flags: got %0h want 0", {k_first, k_last}); end checks++;
        if (a_row_flat[1*DW +: DW] !== 16'h10) begin errors++; $display("FAIL acc_b0_a1: got %0h want 10", a_row_flat[1*DW +: DW]); end checks++;
        tick();
        if ({k_first, k_last} !== 2'b01) begin errors++; $display("FAIL acc_b1_flags: got %0h want 1", {k_first, k_last}); end checks++;
        if (a_row_flat[1*DW +: DW] !== 16'h11) begin errors++; $display("FAIL acc_b1_a1: got %0h want 11", a_row_flat[1*DW +: DW]); end checks++;
        tick();
        if (step_valid !== 1'b0) begin errors++; $display("FAIL acc_drop: got %0h want 0", step_valid); end checks++;
        c_valid_flat = '1;
        tick();
        c_valid_flat = '0;
        tick();
        if (tile_done !== 1'b1) begin errors++; $display("FAIL acc_done: got %0h want 1", tile_done); end checks++;
        tick();
    endtask

    task automatic test_zero_len();
        start_tile(16'd0, 1'b0);
        if (tile_busy !== 1'b1)  begin errors++; $display("FAIL zero_busy: got %0h want 1", tile_busy); end checks++;
        if (res_valid !== 1'b0)  begin errors++; $display("FAIL zero_resv_clear: got %0h want 0", res_valid); end checks++;
        if (tile_done !== 1'b0)  begin errors++; $display("FAIL zero_done_early: got %0h want 0", tile_done); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL zero_valid0: got %0h want 0", step_valid); end checks++;
        tick();
        if (tile_done !== 1'b1)  begin errors++; $display("FAIL zero_done: got %0h want 1", tile_done); end checks++;
        if (tile_err !== 2'd0)   begin errors++; $display("FAIL zero_err: got %0h want 0", tile_err); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL zero_valid1: got %0h want 0", step_valid); end checks++;
        tick();
        if (tile_busy !== 1'b0)  begin errors++; $display("FAIL zero_busy_drop: got %0h want 0", tile_busy); end checks++;
    endtask

    task automatic test_range();
        start_tile(16'(KMAX + 1), 1'b0);
        if (tile_err !== 2'd1)   begin errors++; $display("FAIL range_err0: got %0h want 1", tile_err); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL range_valid0: got %0h want 0", step_valid); end checks++;
        tick();
        if (tile_done !== 1'b1)  begin errors++; $display("FAIL range_done: got %0h want 1", tile_done); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL range_valid1: got %0h want 0", step_valid); end checks++;
        tick();
        if (tile_busy !== 1'b0)  begin errors++; $display("FAIL range_busy_drop: got %0h want 0", tile_busy); end checks++;
        if (tile_err !== 2'd1)   begin errors++; $display("FAIL range_err_hold: got %0h want 1", tile_err); end checks++;
    endtask

    task automatic test_timeout();
        step_ready   = 1'b1;
        c_valid_flat = 16'h7FFF;
        start_tile(16'd1, 1'b0);
        if (tile_err !== 2'd0) begin errors++; $display("FAIL tmo_err_clear: got %0h want 0", tile_err); end checks++;
        tick();
        if ({step_valid, k_first, k_last} !== 3'b111) begin errors++; $display("FAIL tmo_single_beat: got %0h want 7", {step_valid, k_first, k_last}); end checks++;
        tick();
        if (step_valid !== 1'b0) begin errors++; $display("FAIL tmo_drop: got %0h want 0", step_valid); end checks++;
        repeat (DRAIN_TO - 1) tick();
        if (tile_err !== 2'd0)  begin errors++; $display("FAIL tmo_err_early: got %0h want 0", tile_err); end checks++;
        tick();
        if (tile_err !== 2'd2)  begin errors++; $display("FAIL tmo_err: got %0h want 2", tile_err); end checks++;
        tick();
        if (tile_done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %0h want 1", tile_done); end checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL tmo_resv: got %0h want 0", res_valid); end checks++;
        tick();
        c_valid_flat = '0;
    endtask

    task automatic test_abort();
        step_ready = 1'b1;
        start_tile(16'd8, 1'b0);
        tick();
        tick();
        if (a_row_flat[0 +: DW] !== 16'd1) begin errors++; $display("FAIL abort_beat1: got %0h want 1", a_row_flat[0 +: DW]); end checks++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL abort_drop: got %0h want 0", step_valid); end checks++;
        if (tile_done !== 1'b0)  begin errors++; $display("FAIL abort_done_early: got %0h want 0", tile_done); end checks++;
        tick();
        if (tile_done !== 1'b1)  begin errors++; $display("FAIL abort_done: got %0h want 1", tile_done); end checks++;
        if (tile_err !== 2'd3)   begin errors++; $display("FAIL abort_err: got %0h want 3", tile_err); end checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL abort_nobeat: got %0h want 0", step_valid); end checks++;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (tile_busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %0h want 0", tile_busy); end checks++;
        if (tile_err !== 2'd3)  begin errors++; $display("FAIL abort_idle_err: got %0h want 3", tile_err); end checks++;
    endtask

    task automatic test_reset_mid();
        step_ready = 1'b0;
        start_tile(16'd8, 1'b0);
        tick();
        if (step_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %0h want 1", step_valid); end checks++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if ({tile_busy, step_valid, k_first, tile_done} !== 4'b0000) begin errors++; $display("FAIL rmid_ctrl: got %0h want 0", {tile_busy, step_valid, k_first, tile_done}); end checks++;
        if (tile_err !== 2'd0) begin errors++; $display("FAIL rmid_err: got %0h want 0", tile_err); end checks++;
        if (a_row_flat !== '0) begin errors++; $display("FAIL rmid_a: got %0h want 0", a_row_flat); end checks++;
        tick();
        tick();
        if (tile_done !== 1'b0) begin errors++; $display("FAIL rmid_nodone: got %0h want 0", tile_done); end checks++;
        step_ready = 1'b1;
        start_tile(16'd2, 1'b0);
        tick();
        if ({step_valid, k_first, k_last} !== 3'b110) begin errors++; $display("FAIL rmid_b0_flags: got %0h want 6", {step_valid, k_first, k_last}); end checks++;
        if (a_row_flat[3*DW +: DW] !== 16'h30) begin errors++; $display("FAIL rmid_b0_a3: got %0h want 30", a_row_flat[3*DW +: DW]); end checks++;
        tick();
        if ({step_valid, k_first, k_last} !== 3'b101) begin errors++; $display("FAIL rmid_b1_flags: got %0h want 5", {step_valid, k_first, k_last}); end checks++;
        if (a_row_flat[3*DW +: DW] !== 16'h31) begin errors++; $display("FAIL rmid_b1_a3: got %0h want 31", a_row_flat[3*DW +: DW]); end checks++;
        tick();
        c_valid_flat = '1;
        tick();
        c_valid_flat = '0;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL rmid_resv: got %0h want 1", res_valid); end checks++;
        tick();
        if (tile_done !== 1'b1) begin errors++; $display("FAIL rmid_done: got %0h want 1", tile_done); end checks++;
        if (tile_err !== 2'd0)  begin errors++; $display("FAIL rmid_err_ok: got %0h want 0", tile_err); end checks++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < M; i++)
            for (int k = 0; k < KMAX; k++)
                W_tile_flat[(i*KMAX + k)*DW +: DW] = 16'(i*16 + k);
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < N; j++)
                X_tile_flat[(k*N + j)*DW +: DW] = 16'(k*16 + j);
        for (int p = 0; p < M*N; p++) begin
            c_out_flat[p*DW +: DW] = 16'(16'h0A00 + p);
            exp_res[p*DW +: DW]    = 16'(16'h0A00 + p);
        end

        test_reset();
        test_basic();
        test_stall();
        test_acc();
        test_zero_len();
        test_range();
        test_timeout();
        test_abort();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
